// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of one register-file write port among NREQ sources.
// Define REGFILE_ARB_STATS_EN to add saturating grant_count/drop_count statistics outputs.
module regfile_write_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      WriteData,
    output logic [AW-1:0]      WriteRegister,
    output logic               RegWrite,
`ifdef REGFILE_ARB_STATS_EN
    output logic               busy,
    output logic [NREQ*16-1:0] grant_count,
    output logic [15:0]        drop_count
`else
    output logic               busy
`endif
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    generate
        if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
            $error("regfile_write_arbiter: NREQ must be in 2..4");
        end
    endgenerate

    function automatic logic [NREQ-1:0] lowest_one(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r;
        logic            found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && v[i]) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] above_ptr;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] win_oh_p0;
    logic [PW-1:0]   win_idx_p0;
    logic            grant_p0;
    logic [AW-1:0]   addr_p0;
    logic [DW-1:0]   data_p0;

    logic [DW-1:0]   wr_data_p1;
    logic [AW-1:0]   wr_addr_p1;
    logic            wr_en_p1;
    logic            vld_p1;

    // Stage p0: requests strictly after rr_ptr win first; otherwise wrap to the lowest index.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < NREQ; i++) begin
            above_ptr[i] = (PW'(i) > rr_ptr);
        end
        hi_req    = req_valid & above_ptr;
        win_oh_p0 = (hi_req != '0) ? lowest_one(hi_req) : lowest_one(req_valid);
        grant_p0  = !Reset && !Hold && (req_valid != '0);
    end

    always_comb begin
        win_idx_p0 = '0;
        addr_p0    = '0;
        data_p0    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh_p0[i]) begin
                win_idx_p0 = PW'(i);
                addr_p0    = req_addr[i*AW +: AW];
                data_p0    = req_data[i*DW +: DW];
            end
        end
    end

    assign req_ready = grant_p0 ? win_oh_p0 : '0;

    // Stage p1: registered write port; address 0 completes the handshake but never writes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_data_p1 <= '0;
            wr_addr_p1 <= '0;
            wr_en_p1   <= 1'b0;
            vld_p1     <= 1'b0;
            rr_ptr     <= PW'(NREQ - 1);
        end else if (grant_p0) begin
            wr_data_p1 <= data_p0;
            wr_addr_p1 <= addr_p0;
            wr_en_p1   <= (addr_p0 != '0);
            vld_p1     <= 1'b1;
            rr_ptr     <= win_idx_p0;
        end else begin
            wr_en_p1   <= 1'b0;
            vld_p1     <= 1'b0;
        end
    end

    assign WriteData     = wr_data_p1;
    assign WriteRegister = wr_addr_p1;
    assign RegWrite      = wr_en_p1;
    assign busy          = vld_p1;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];
    logic [15:0] drop_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
            drop_cnt <= '0;
        end else if (grant_p0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win_oh_p0[i]) begin
                    grant_cnt[i] <= sat_inc16(grant_cnt[i]);
                end
            end
            if (addr_p0 == '0) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end
        end
    end

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_cnt
            assign grant_count[g*16 +: 16] = grant_cnt[g];
        end
    endgenerate

    assign drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Hold;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      WriteData;
    logic [AW-1:0]      WriteRegister;
    logic               RegWrite;
    logic               busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_count;
    logic [15:0]        drop_count;
`endif

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Hold          (Hold),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .WriteData     (WriteData),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
`ifdef REGFILE_ARB_STATS_EN
        .busy          (busy),
        .grant_count   (grant_count),
        .drop_count    (drop_count)
`else
        .busy          (busy)
`endif
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus state
    logic [NREQ-1:0] v;
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];

    // behavioural model
    int            m_rr;
    logic [DW-1:0] m_wd;
    logic [AW-1:0] m_wr;
    logic          m_we;
    logic          m_busy;
    int            m_grants [NREQ];
    int            m_drops;
    logic [DW-1:0] m_rf   [32];
    logic [DW-1:0] dut_rf [32];
    int            last_w;
    logic [NREQ-1:0] last_rdy;

    always @(posedge Clk) begin
        if (RegWrite === 1'b1) dut_rf[WriteRegister] <= WriteData;
    end

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = v[i];
            req_addr[i*AW +: AW]  = a[i];
            req_data[i*DW +: DW]  = d[i];
        end
    endtask

    task automatic m_reset();
        m_rr = NREQ - 1; m_wd = '0; m_wr = '0; m_we = 1'b0; m_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) m_grants[i] = 0;
        m_drops = 0;
    endtask

    function automatic int pick_winner();
        int idx;
        if (Hold) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int sat16(input int c);
        return (c > 65535) ? 65535 : c;
    endfunction

    // Called just after a posedge with inputs driven; returns just after the next posedge.
    task automatic step(input string tag);
        int w;
        logic [NREQ-1:0] exp_rdy;
        @(negedge Clk);
        w       = pick_winner();
        exp_rdy = (w >= 0) ? NREQ'(1 << w) : '0;
        last_rdy = req_ready;
        check_val({tag, "/ready"}, req_ready, exp_rdy);
        check_val({tag, "/regwrite"}, RegWrite, m_we);
        check_val({tag, "/busy"}, busy, m_busy);
        check_val({tag, "/wreg"}, WriteRegister, m_wr);
        check_val({tag, "/wdata"}, WriteData, m_wd);
`ifdef REGFILE_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check_val({tag, "/gcnt"}, grant_count[i*16 +: 16], 64'(sat16(m_grants[i])));
        check_val({tag, "/dcnt"}, drop_count, 64'(sat16(m_drops)));
`endif
        if (m_we) m_rf[m_wr] = m_wd;
        if (w >= 0) begin
            m_wd = d[w]; m_wr = a[w]; m_we = (a[w] != 0); m_busy = 1'b1; m_rr = w;
            m_grants[w]++;
            if (a[w] == 0) m_drops++;
        end else begin
            m_we = 1'b0; m_busy = 1'b0;
        end
        last_w = w;
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Hold = 1'b0; v = '1; apply();
        #2;
        check_val("rst/regwrite", RegWrite, 1'b0);
        check_val("rst/busy", busy, 1'b0);
        check_val("rst/wdata", WriteData, '0);
        check_val("rst/wreg", WriteRegister, '0);
        check_val("rst/ready", req_ready, '0);
        m_reset();
        @(posedge Clk); #1;
        Reset = 1'b0; v = '0; apply();
    endtask

    initial begin
        Reset = 1'b0; Hold = 1'b0; v = '0;
        for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
        apply();
        m_reset();
        #1;
        do_reset();

        // 1: single write, latency
        v = 2'b01; a[0] = 5'd3; d[0] = 32'hDEADBEEF; apply();
        step("t1");
        check_val("t1/rdy0", last_rdy, 2'b01);
        check_val("t1/rw", RegWrite, 1'b1);
        check_val("t1/wr", WriteRegister, 5'd3);
        check_val("t1/wd", WriteData, 32'hDEADBEEF);
        v = '0; apply();
        step("t1b");

        // 2: alternation between two continuously valid sources
        do_reset();
        v = 2'b11; a[0] = 5'd4; a[1] = 5'd9; d[0] = $urandom; d[1] = $urandom; apply();
        for (int k = 0; k < 6; k++) begin
            step("t2");
            check_val("t2/order", last_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            check_val("t2/rw", RegWrite, 1'b1);
        end
        v = '0; apply();
        step("t2b");

        // 3: address 0 accepted but not issued
        v = 2'b10; a[1] = 5'd0; d[1] = 32'd5; apply();
        step("t3");
        check_val("t3/rdy1", last_rdy, 2'b10);
        check_val("t3/rw", RegWrite, 1'b0);
        check_val("t3/busy", busy, 1'b1);
`ifdef REGFILE_ARB_STATS_EN
        check_val("t3/drop", drop_count, 16'd1);
`endif
        v = '0; apply();
        step("t3b");

        // 4: Hold blocks grants
        Hold = 1'b1; v = 2'b01; a[0] = 5'd31; d[0] = $urandom; apply();
        for (int k = 0; k < 3; k++) begin
            step("t4h");
            check_val("t4/hold_rdy", last_rdy, 2'b00);
            check_val("t4/hold_rw", RegWrite, 1'b0);
        end
        Hold = 1'b0; apply();
        step("t4");
        check_val("t4/rdy0", last_rdy, 2'b01);
        check_val("t4/wr", WriteRegister, 5'd31);
        check_val("t4/rw", RegWrite, 1'b1);

        // 5: asynchronous reset mid-transfer
        v = '0; apply();
        Reset = 1'b1;
        #1;
        check_val("t5/rw", RegWrite, 1'b0);
        check_val("t5/busy", busy, 1'b0);
        m_reset();
        @(posedge Clk); #1;
        Reset = 1'b0; v = 2'b11; a[0] = 5'd12; a[1] = 5'd13; d[0] = $urandom; d[1] = $urandom; apply();
        step("t5");
        check_val("t5/first", last_rdy, 2'b01);
        v = '0; apply();
        step("t5b");

        // randomized traffic with collisions, withdrawals and Hold
        for (int c = 0; c < 3000; c++) begin
            Hold = ($urandom_range(9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i]) begin
                    if ($urandom_range(2) != 0) begin
                        v[i] = 1'b1;
                        a[i] = ($urandom_range(4) == 0) ? AW'($urandom) : AW'($urandom_range(3));
                        d[i] = $urandom;
                    end
                end else if ($urandom_range(15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            apply();
            step("rand");
            if (last_w >= 0) v[last_w] = 1'b0;
        end
        Hold = 1'b0; v = '0; apply();
        step("drain");
        step("drain");
        for (int r = 0; r < 32; r++) check_val("regfile", dut_rf[r], m_rf[r]);

`ifdef REGFILE_ARB_STATS_EN
        // 6: grant counter saturation
        do_reset();
        v = 2'b01; a[0] = 5'd7; d[0] = 32'h1234; apply();
        for (int k = 0; k < 65540; k++) step("t6");
        check_val("t6/sat", grant_count[15:0], 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
